// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor: res1 = (a1 - b1) mod 2^WIDTH, borrow = a1 < b1, DIGIT bits/cycle LSD first.
// Latency: accept edge T, out_valid high after edge T+NDIG; minimum issue interval NDIG+2 cycles.
// Backpressure: one op in flight; in_ready low in BUSY/DONE, result held indefinitely while out_ready=0.
// Build option SUB_SATURATE_EN: floor the result at zero whenever the final borrow is set.
module digit_serial_subtractor #(
    parameter int WIDTH = 17,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res1,
    output logic             borrow
);

    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int WPAD = NDIG * DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    // Operands are zero-padded to whole digits; a zero-padded partial top digit
    // yields the same borrow-out as taking it at the top real bit.
    logic [WPAD-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0] res_reg, res_next;
    logic             borrow_reg;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic             last_dig;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   diff;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign res1      = res_reg;
    assign borrow    = borrow_reg;

    // Current digit subtract and merge of its real bits into the result.
    always_comb begin
        a_dig    = '0;
        b_dig    = '0;
        res_next = res_reg;
        last_dig = (int'(cnt) == NDIG - 1);
        for (int j = 0; j < WPAD; j++) begin
            if (j / DIGIT == int'(cnt)) begin
                a_dig[j % DIGIT] = a_reg[j];
                b_dig[j % DIGIT] = b_reg[j];
            end
        end
        diff = {1'b0, a_dig} - {1'b0, b_dig} - (DIGIT + 1)'(bin);
        for (int j = 0; j < WIDTH; j++) begin
            if (j / DIGIT == int'(cnt)) begin
                res_next[j] = diff[j % DIGIT];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, step through NDIG digits, hold until consumed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_dig)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one digit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            bin        <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= WPAD'(a1);
                        b_reg <= WPAD'(b1);
                        bin   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    res_reg <= res_next;
                    bin     <= diff[DIGIT];
                    cnt     <= cnt + 1'b1;
                    if (last_dig) begin
                        borrow_reg <= diff[DIGIT];
`ifdef SUB_SATURATE_EN
                        if (diff[DIGIT]) begin
                            res_reg <= '0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed and back-to-back self-checking bench for digit_serial_subtractor at WIDTH=17, DIGIT=4.
// Latency: expects out_valid after the 5th edge past acceptance and a 7-cycle issue interval.
// Backpressure: holds out_ready low to verify result stability and that new requests are ignored.
module tb_digit_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] a1;
    logic [16:0] b1;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] res1;
    logic        borrow;

    int checks = 0;
    int errors = 0;

    digit_serial_subtractor #(.WIDTH(17), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a1        (a1),
        .b1        (b1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res1      (res1),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    // Present one operation for a single edge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [16:0] a, input logic [16:0] b);
        @(negedge clk);
        a1       = a;
        b1       = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid is seen, bounded at 50.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (res1 !== 17'h0)     begin errors++; $display("FAIL reset_res1 got %h want 0", res1); end
        checks++; if (borrow !== 1'b0)    begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        start_op(17'd100, 17'd30);
        wait_valid(lat);
        checks++; if (lat != 5)        begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (res1 !== 17'd70) begin errors++; $display("FAIL basic_res1 got %0d want 70", res1); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow got %b want 0", borrow); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_drop got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL basic_in_ready_rise got %b want 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [16:0] va [5];
        logic [16:0] vb [5];
        logic [16:0] vr [5];
        logic        vbr[5];
        int lat;
        va[0] = 17'h00000; vb[0] = 17'h00001; vbr[0] = 1'b1;
        va[1] = 17'h1FFFF; vb[1] = 17'h1FFFF; vr[1] = 17'h00000; vbr[1] = 1'b0;
        va[2] = 17'h10000; vb[2] = 17'h0FFFF; vr[2] = 17'h00001; vbr[2] = 1'b0;
        va[3] = 17'h0ABCD; vb[3] = 17'h01234; vr[3] = 17'h09999; vbr[3] = 1'b0;
        va[4] = 17'h00001; vb[4] = 17'h1FFFF; vbr[4] = 1'b1;
`ifdef SUB_SATURATE_EN
        vr[0] = 17'h00000;
        vr[4] = 17'h00000;
`else
        vr[0] = 17'h1FFFF;
        vr[4] = 17'h00002;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_valid(lat);
            checks++; if (lat != 5)          begin errors++; $display("FAIL vec%0d_latency got %0d want 5", i, lat); end
            checks++; if (res1 !== vr[i])    begin errors++; $display("FAIL vec%0d_res1 got %h want %h", i, res1, vr[i]); end
            checks++; if (borrow !== vbr[i]) begin errors++; $display("FAIL vec%0d_borrow got %b want %b", i, borrow, vbr[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_op(17'h12345, 17'h00345);
        wait_valid(lat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %b want 1", out_valid); end
        a1       = 17'd3;
        b1       = 17'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (res1 !== 17'h12000) begin errors++; $display("FAIL bp_res1_hold%0d got %h want 12000", k, res1); end
            checks++; if (borrow !== 1'b0)    begin errors++; $display("FAIL bp_borrow_hold%0d got %b want 0", k, borrow); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid%0d got %b want 1", k, out_valid); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_no_ghost_op got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [16:0] exp_r;
        out_ready = 1'b1;
        start_op(17'd7, 17'd3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        checks++; if (res1 !== 17'h0)     begin errors++; $display("FAIL rmid_res1 got %h want 0", res1); end
        checks++; if (borrow !== 1'b0)    begin errors++; $display("FAIL rmid_borrow got %b want 0", borrow); end
`ifdef SUB_SATURATE_EN
        exp_r = 17'h00000;
`else
        exp_r = 17'h1FFFC;
`endif
        start_op(17'd5, 17'd9);
        wait_valid(lat);
        checks++; if (lat != 5)        begin errors++; $display("FAIL rmid_latency got %0d want 5", lat); end
        checks++; if (res1 !== exp_r)  begin errors++; $display("FAIL rmid_res1_after got %h want %h", res1, exp_r); end
        checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL rmid_borrow_after got %b want 1", borrow); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [17:0] expq[$];
        logic [17:0] exp_v;
        logic [16:0] dif;
        int nacc = 0;
        int nres = 0;
        int cyc  = 0;
        int last_acc = -1;
        bit stop = 0;
        out_ready = 1'b1;
        @(negedge clk);
        a1       = 17'($urandom);
        b1       = 17'($urandom);
        in_valid = 1'b1;
        while (nres < 1000 && cyc < 9000) begin
            if (out_valid) begin
                exp_v = expq.pop_front();
                checks++;
                if ({borrow, res1} !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_result%0d got borrow=%b res1=%h want borrow=%b res1=%h",
                             nres, borrow, res1, exp_v[17], exp_v[16:0]);
                end
                nres++;
            end
            if (in_ready && in_valid) begin
                dif = a1 - b1;
`ifdef SUB_SATURATE_EN
                if (a1 < b1) dif = 17'h0;
`endif
                expq.push_back({(a1 < b1), dif});
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 7) begin
                        errors++;
                        $display("FAIL b2b_interval got %0d want 7", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                nacc++;
                if (nacc == 1000) stop = 1;
            end
            @(negedge clk);
            cyc++;
            if (stop) in_valid = 1'b0;
            if (!in_ready) begin
                a1 = 17'($urandom);
                b1 = 17'($urandom);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nres != 1000) begin
            errors++;
            $display("FAIL b2b_count got %0d want 1000", nres);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a1        = '0;
        b1        = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
